keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 hex matrix keypad and debounces it, so the keypad is the input counterpart of the multiplexed
//  seven-segment output path. Drives one column low at a time, samples the active-low rows and detects a single
//  pressed key. Each accepted key is shifted into a 32-bit hex entry register, which feeds the
//  SEVEN_SEGMENT_DRIVER data input directly.
// PARAMETERS
//  SCAN_DIV  100000  clocks per column step (1 ms at 100 MHz); must be >= 2
//  DEBOUNCE  4       consecutive identical full scans required to accept a press or a release; must be >= 1
// PORTS
//  clk        in   1   system clock (100 MHz)
//  rst_n      in   1   asynchronous active-low reset
//  row        in   4   keypad rows, active-low, externally pulled up, asynchronous to clk
//  clear      in   1   synchronous clear of data, one-cycle pulse
//  col        out  4   keypad column drive, active-low, exactly one bit low at any time
//  key_valid  out  1   one-cycle pulse when a key press is accepted
//  key_code   out  4   hex value of the last accepted key
//  key_held   out  1   high while the accepted key is still considered pressed
//  data       out  32  hex entry register; newest key sits in data[3:0]
// BEHAVIOUR
//  Reset values: col=4'b1110, key_valid=0, key_code=0, key_held=0, data=0, FSM=IDLE, all counters=0.
//  Row sync: row passes through a 2-FF synchronizer before any use.
//  Divider: div counts 0..SCAN_DIV-1 and wraps. tick=1 when div==SCAN_DIV-1.
//  Column step: on tick, sample the synced rows for the current column cidx. Then cidx<=cidx+1 (mod 4).
//   col = ~(4'b0001<<cidx).
//  Scan result: evaluated on the tick where cidx==3 (end of scan); one full scan = 4*SCAN_DIV clocks.
//   - NONE: no row was low in any column.
//   - KEY(k): exactly one row/column position was low during the scan.
//   - MULTI: two or more positions were low. MULTI is treated as NONE (anti-ghosting).
//  Keymap [row][col 0..3]:
//   row0: 1 2 3 A
//   row1: 4 5 6 B
//   row2: 7 8 9 C
//   row3: 0 F E D
//  FSM (evaluated only at end of scan; cnt is a debounce counter):
//   IDLE:     KEY(k) -> DEBNC with cand=k, cnt=1 (if DEBOUNCE==1, accept immediately instead).
//   DEBNC:    KEY(cand) -> cnt++; when cnt reaches DEBOUNCE, accept and go to PRESSED.
//             Any other result -> IDLE.
//   PRESSED:  NONE -> RELSE with cnt=1. Any key, including a different one -> stay; no autorepeat.
//   RELSE:    NONE -> cnt++; when cnt reaches DEBOUNCE -> IDLE. Any key -> PRESSED.
//  Accept: in the same cycle, key_valid<=1, key_code<=cand and data<={data[27:0],cand}.
//   The oldest digit drops out of data[31:28]. key_valid falls the next cycle.
//  key_held=1 in PRESSED and RELSE, 0 otherwise.
//  clear: data<=0 on the next edge. If clear coincides with an accept, clear wins for data.
//   key_valid and key_code still update.
//  Latency: press to key_valid is at most (DEBOUNCE+1) scans plus 2 sync cycles.
//  Reset asserted mid-scan or mid-debounce returns all state immediately to the reset values; no key_valid pulse.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE=2; one scan = 16 clk)
//  1 Reset: assert rst_n=0, release -> col=1110, data=0, key_valid=0, col rotates 1110->1101->1011->0111 every 4 clk.
//  2 Hold key 5 (row1 low when col1 low) for 4 scans -> exactly one key_valid, key_code=5, data=32'h00000005, key_held=1.
//  3 Enter 1..9 with a 3-scan release between keys -> data=32'h23456789 and 9 key_valid pulses.
//  4 Bounce: key 7 for 1 scan, then released -> no key_valid, data unchanged.
//  5 Press A and 3 at the same time for 5 scans -> no key_valid. Hold 0, then add F -> only one pulse (code 0).
//  6 Assert clear in the accept cycle of key C -> data=0, key_code=C. Drop rst_n mid-DEBNC -> all outputs at reset values.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x4 hex keypad with anti-ghosting and
// scan-level debounce. Accepted keys shift into a 32-bit hex entry register
// that drives the seven-segment display data input directly.
module keypad_scanner #(
    parameter int SCAN_DIV = 100000,  // clocks per column step, >= 2
    parameter int DEBOUNCE = 4        // identical full scans to accept press/release, >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] data
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, DEBNC, PRESSED, RELSE} state_t;

    logic [3:0]       row_sync1_reg, row_sync2_reg;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       cidx_reg;
    logic [15:0]      hits_reg;
    logic [15:0]      cur_hits;
    state_t           state_reg, state_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             key_valid_reg;
    logic [3:0]       key_code_reg;
    logic [31:0]      data_reg;

    logic        tick, scan_end;
    logic        found_one, found_multi, key_seen;
    logic [3:0]  hit_pos, seen_code;
    logic        accept;
    logic [3:0]  accept_code;

    // Physical key position {row, col} to hex value.
    function automatic logic [3:0] key_of(input logic [3:0] pos);
        case (pos)
            4'd0:  key_of = 4'h1;
            4'd1:  key_of = 4'h2;
            4'd2:  key_of = 4'h3;
            4'd3:  key_of = 4'hA;
            4'd4:  key_of = 4'h4;
            4'd5:  key_of = 4'h5;
            4'd6:  key_of = 4'h6;
            4'd7:  key_of = 4'hB;
            4'd8:  key_of = 4'h7;
            4'd9:  key_of = 4'h8;
            4'd10: key_of = 4'h9;
            4'd11: key_of = 4'hC;
            4'd12: key_of = 4'h0;
            4'd13: key_of = 4'hF;
            4'd14: key_of = 4'hE;
            default: key_of = 4'hD;
        endcase
    endfunction

    assign tick     = (div_reg == DIV_LAST);
    assign scan_end = tick && (cidx_reg == 2'd3);
    assign col      = ~(4'b0001 << cidx_reg);

    // Two-flop synchronizer; idle level is all rows released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sync1_reg <= 4'hF;
            row_sync2_reg <= 4'hF;
        end else begin
            row_sync1_reg <= row;
            row_sync2_reg <= row_sync1_reg;
        end
    end

    // Column step divider and column index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            cidx_reg <= 2'd0;
        end else if (tick) begin
            div_reg  <= '0;
            cidx_reg <= cidx_reg + 2'd1;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Hits so far this scan, merged with the rows seen on the current column.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hits
            assign cur_hits[gi] = hits_reg[gi] |
                                  (~row_sync2_reg[gi / 4] & (cidx_reg == 2'(gi % 4)));
        end
    endgenerate

    // Accumulate hits across the scan; cleared once the scan is evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_reg <= '0;
        end else if (tick) begin
            hits_reg <= scan_end ? 16'h0000 : cur_hits;
        end
    end

    // Classify the scan: exactly one hit is a key, several hits are ignored.
    always_comb begin
        found_one   = 1'b0;
        found_multi = 1'b0;
        hit_pos     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cur_hits[i]) begin
                if (found_one) found_multi = 1'b1;
                found_one = 1'b1;
                hit_pos   = 4'(i);
            end
        end
        key_seen  = found_one && !found_multi;
        seen_code = key_of(hit_pos);
    end

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cand_reg  <= 4'h0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Debounce FSM next state; only moves at the end of a full scan.
    always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        cnt_next    = cnt_reg;
        accept      = 1'b0;
        accept_code = cand_reg;
        if (scan_end) begin
            case (state_reg)
                IDLE: begin
                    if (key_seen) begin
                        cand_next = seen_code;
                        if (DEBOUNCE == 1) begin
                            accept      = 1'b1;
                            accept_code = seen_code;
                            state_next  = PRESSED;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = DEBNC;
                        end
                    end
                end
                DEBNC: begin
                    if (key_seen && (seen_code == cand_reg)) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg + CNT_W'(1) == CNT_TGT) begin
                            accept     = 1'b1;
                            state_next = PRESSED;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                PRESSED: begin
                    if (!key_seen) begin
                        cnt_next   = CNT_W'(1);
                        state_next = (DEBOUNCE == 1) ? IDLE : RELSE;
                    end
                end
                default: begin  // RELSE
                    if (key_seen) begin
                        state_next = PRESSED;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg + CNT_W'(1) == CNT_TGT) state_next = IDLE;
                    end
                end
            endcase
        end
    end

    // Output registers; clear overrides an accept for the entry register only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'h0;
            data_reg      <= 32'h0;
        end else begin
            key_valid_reg <= accept;
            if (accept) key_code_reg <= accept_code;
            if (clear) data_reg <= 32'h0;
            else if (accept) data_reg <= {data_reg[27:0], accept_code};
        end
    end

    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign data      = data_reg;
    assign key_held  = (state_reg == PRESSED) || (state_reg == RELSE);

endmodule
